// File: rtl/matinv_pkg.sv
// Shared defaults, FSM state type and index helper for the 3x3 fixed-point
// matrix inversion back-end.
package matinv_pkg;
  localparam int SIZE_DEF = 16;
  localparam int FRAC_DEF = 12;
  localparam int N        = 3;
  localparam int NN       = N * N;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_R,
    WAIT_Q,
    COMPUTE,
    OUT
  } state_e;

  // Row-major flat index of a 3x3 element.
  function automatic logic [3:0] idx3(input logic [1:0] row, input logic [1:0] col);
    return 4'(row) * 4'd3 + 4'(col);
  endfunction
endpackage

// File: rtl/fxp_mac_sat.sv
// Signed multiply-accumulate with FRAC-bit arithmetic right shift and
// saturation back to SIZE bits; res reflects the sum including this cycle's term.
module fxp_mac_sat #(
  parameter int SIZE = 16,
  parameter int FRAC = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            clr,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic [SIZE-1:0] res
);
  localparam int AW = 2 * SIZE + 2;
  localparam logic signed [AW-1:0] MAX_V = {{(AW-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [AW-1:0] MIN_V = {{(AW-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

  logic signed [2*SIZE-1:0] prod;
  logic signed [AW-1:0]     acc_q, acc_d, sum, shifted;

  always_comb begin
    prod    = $signed(a) * $signed(b);
    sum     = (clr ? '0 : acc_q) + {{2{prod[2*SIZE-1]}}, prod};
    acc_d   = en ? sum : acc_q;
    shifted = sum >>> FRAC;
    if (shifted > MAX_V)      res = MAX_V[SIZE-1:0];
    else if (shifted < MIN_V) res = MIN_V[SIZE-1:0];
    else                      res = shifted[SIZE-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/rinv_qt_mult.sv
// Computes A_inv = R_inv x Q^T for 3x3 fixed-point matrices: streams R_inv in,
// collects Q, runs 27 serial MACs, then serves the result on request.
//   state   | meaning
//   IDLE    | waiting for rinv_dnload; Q may already be arriving
//   LOAD_R  | 9 read requests issued, elements captured one cycle later
//   WAIT_Q  | R_inv complete, waiting until all 9 Q elements are held
//   COMPUTE | one MAC per cycle, i outer / j middle / k inner
//   OUT     | result buffer readable, one element per ainv_read
module rinv_qt_mult
  import matinv_pkg::*;
#(
  parameter int SIZE = SIZE_DEF,
  parameter int FRAC = FRAC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            rinv_dnload,
  output logic            rinv_read,
  input  logic [SIZE-1:0] rinv_elem,
  input  logic            rinv_finish,
  input  logic            q_valid,
  input  logic [SIZE-1:0] q_elem,
  input  logic            ainv_read,
  output logic            ainv_ready,
  output logic [SIZE-1:0] ainv_elem,
  output logic            ainv_valid,
  output logic            ainv_finish
);
  localparam logic [3:0] NN_C = 4'(NN);

  state_e          state_q, state_d;
  logic [3:0]      rd_cnt_q, rd_cnt_d, r_idx_q, r_idx_d;
  logic [3:0]      q_idx_q, q_idx_d, out_idx_q, out_idx_d;
  logic            rd_pend_q, rd_pend_d;
  logic [1:0]      i_q, i_d, j_q, j_d, k_q, k_d;
  logic [SIZE-1:0] r_buf_q [NN];
  logic [SIZE-1:0] r_buf_d [NN];
  logic [SIZE-1:0] q_buf_q [NN];
  logic [SIZE-1:0] q_buf_d [NN];
  logic [SIZE-1:0] res_buf_q [NN];
  logic [SIZE-1:0] res_buf_d [NN];
  logic            ainv_ready_q, ainv_ready_d;
  logic            ainv_valid_q, ainv_valid_d;
  logic            ainv_finish_q, ainv_finish_d;
  logic [SIZE-1:0] ainv_elem_q, ainv_elem_d;
  logic            rinv_read_d;
  logic            mac_en, mac_clr;
  logic [SIZE-1:0] mac_a, mac_b, mac_res;
  logic            unused_rinv_finish;

  // End-of-stream is known from the element count alone.
  assign unused_rinv_finish = rinv_finish;

  fxp_mac_sat #(.SIZE(SIZE), .FRAC(FRAC)) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_en),
    .clr   (mac_clr),
    .a     (mac_a),
    .b     (mac_b),
    .res   (mac_res)
  );

  always_comb begin
    state_d       = state_q;
    rd_cnt_d      = rd_cnt_q;
    r_idx_d       = r_idx_q;
    q_idx_d       = q_idx_q;
    out_idx_d     = out_idx_q;
    rd_pend_d     = 1'b0;
    i_d           = i_q;
    j_d           = j_q;
    k_d           = k_q;
    r_buf_d       = r_buf_q;
    q_buf_d       = q_buf_q;
    res_buf_d     = res_buf_q;
    ainv_ready_d  = ainv_ready_q;
    ainv_valid_d  = 1'b0;
    ainv_finish_d = ainv_finish_q;
    ainv_elem_d   = ainv_elem_q;
    rinv_read_d   = 1'b0;
    mac_en        = 1'b0;
    mac_clr       = (k_q == 2'd0);
    mac_a         = r_buf_q[idx3(i_q, k_q)];
    mac_b         = q_buf_q[idx3(j_q, k_q)];

    if (start) begin
      state_d       = IDLE;
      rd_cnt_d      = '0;
      r_idx_d       = '0;
      q_idx_d       = '0;
      out_idx_d     = '0;
      i_d           = '0;
      j_d           = '0;
      k_d           = '0;
      ainv_ready_d  = 1'b0;
      ainv_finish_d = 1'b0;
    end else begin
      if (q_valid && (q_idx_q < NN_C) && (state_q inside {IDLE, LOAD_R, WAIT_Q})) begin
        q_buf_d[q_idx_q] = q_elem;
        q_idx_d          = q_idx_q + 4'd1;
      end
      if (rd_pend_q) begin
        r_buf_d[r_idx_q] = rinv_elem;
        r_idx_d          = r_idx_q + 4'd1;
      end

      case (state_q)
        IDLE: begin
          if (rinv_dnload) begin
            state_d  = LOAD_R;
            rd_cnt_d = '0;
            r_idx_d  = '0;
          end
        end
        LOAD_R: begin
          if (rd_cnt_q < NN_C) begin
            rinv_read_d = 1'b1;
            rd_cnt_d    = rd_cnt_q + 4'd1;
            rd_pend_d   = 1'b1;
          end
          if (rd_pend_q && (r_idx_q == NN_C - 4'd1)) state_d = WAIT_Q;
        end
        WAIT_Q: begin
          if (q_idx_q == NN_C) begin
            state_d = COMPUTE;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
          end
        end
        COMPUTE: begin
          mac_en = 1'b1;
          if (k_q == 2'd2) begin
            res_buf_d[idx3(i_q, j_q)] = mac_res;
            k_d = '0;
            if (j_q == 2'd2) begin
              j_d = '0;
              if (i_q == 2'd2) begin
                i_d          = '0;
                state_d      = OUT;
                ainv_ready_d = 1'b1;
                out_idx_d    = '0;
              end else begin
                i_d = i_q + 2'd1;
              end
            end else begin
              j_d = j_q + 2'd1;
            end
          end else begin
            k_d = k_q + 2'd1;
          end
        end
        OUT: begin
          if (ainv_read && (out_idx_q < NN_C)) begin
            ainv_elem_d  = res_buf_q[out_idx_q];
            ainv_valid_d = 1'b1;
            out_idx_d    = out_idx_q + 4'd1;
            if (out_idx_q == NN_C - 4'd1) ainv_finish_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rd_cnt_q      <= '0;
      r_idx_q       <= '0;
      q_idx_q       <= '0;
      out_idx_q     <= '0;
      rd_pend_q     <= 1'b0;
      i_q           <= '0;
      j_q           <= '0;
      k_q           <= '0;
      ainv_ready_q  <= 1'b0;
      ainv_valid_q  <= 1'b0;
      ainv_finish_q <= 1'b0;
      ainv_elem_q   <= '0;
      for (int n = 0; n < NN; n++) begin
        r_buf_q[n]   <= '0;
        q_buf_q[n]   <= '0;
        res_buf_q[n] <= '0;
      end
    end else begin
      state_q       <= state_d;
      rd_cnt_q      <= rd_cnt_d;
      r_idx_q       <= r_idx_d;
      q_idx_q       <= q_idx_d;
      out_idx_q     <= out_idx_d;
      rd_pend_q     <= rd_pend_d;
      i_q           <= i_d;
      j_q           <= j_d;
      k_q           <= k_d;
      ainv_ready_q  <= ainv_ready_d;
      ainv_valid_q  <= ainv_valid_d;
      ainv_finish_q <= ainv_finish_d;
      ainv_elem_q   <= ainv_elem_d;
      r_buf_q       <= r_buf_d;
      q_buf_q       <= q_buf_d;
      res_buf_q     <= res_buf_d;
    end
  end

  assign rinv_read   = rinv_read_d;
  assign ainv_ready  = ainv_ready_q;
  assign ainv_valid  = ainv_valid_q;
  assign ainv_finish = ainv_finish_q;
  assign ainv_elem   = ainv_elem_q;
endmodule

// File: tb/tb_rinv_qt_mult.sv
// Directed bench for rinv_qt_mult: hand-computed A_inv vectors, handshake
// timing, saturation, start and reset recovery.
module tb_rinv_qt_mult;
  logic        clk = 1'b0;
  logic        rst_n, start, rinv_dnload, rinv_finish, q_valid, ainv_read;
  logic [15:0] rinv_elem, q_elem;
  logic        rinv_read, ainv_ready, ainv_valid, ainv_finish;
  logic [15:0] ainv_elem;

  int errors = 0;
  int checks = 0;
  logic [15:0] r_v [9];
  logic [15:0] q_v [9];
  logic [15:0] e_v [9];

  rinv_qt_mult #(.SIZE(16), .FRAC(12)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .rinv_dnload (rinv_dnload),
    .rinv_read   (rinv_read),
    .rinv_elem   (rinv_elem),
    .rinv_finish (rinv_finish),
    .q_valid     (q_valid),
    .q_elem      (q_elem),
    .ainv_read   (ainv_read),
    .ainv_ready  (ainv_ready),
    .ainv_elem   (ainv_elem),
    .ainv_valid  (ainv_valid),
    .ainv_finish (ainv_finish)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_q(input bit extra);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      q_valid = 1'b1;
      q_elem  = q_v[k];
    end
    if (extra) begin
      @(negedge clk);
      q_elem = 16'h7FFF;
    end
    @(negedge clk);
    q_valid = 1'b0;
    q_elem  = '0;
  endtask

  // Upstream model: element presented in the cycle after each request.
  task automatic run_load(input int stop_at, input bit timing);
    int ridx = 0, rd_hi = 0, first_rd = 0, last_rd = 0, first_rdy = 0;
    bit prev_rd = 1'b0, seen = 1'b0;
    rinv_dnload = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      rinv_dnload = 1'b0;
      rinv_finish = 1'b0;
      if (prev_rd && ridx < 9) begin
        rinv_elem   = r_v[ridx];
        rinv_finish = (ridx == 8);
        ridx++;
      end
      prev_rd = rinv_read;
      if (rinv_read) begin
        if (rd_hi == 0) first_rd = c;
        rd_hi++;
        last_rd = c;
      end
      if (c == stop_at) return;
      if (ainv_ready) begin
        seen = 1'b1;
        first_rdy = c;
        break;
      end
    end
    chk("rd_count", rd_hi, 9);
    chk("rd_contig", last_rd - first_rd, 8);
    chk("ready_seen", seen, 1);
    if (timing) chk("ready_latency", first_rdy - last_rd, 30);
  endtask

  task automatic readout();
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k > 0) chk($sformatf("valid_gap%0d", k), ainv_valid, 0);
      ainv_read = 1'b1;
      @(negedge clk);
      ainv_read = 1'b0;
      chk($sformatf("valid%0d", k), ainv_valid, 1);
      chk($sformatf("elem%0d", k), ainv_elem, e_v[k]);
      chk($sformatf("finish%0d", k), ainv_finish, (k == 8));
    end
    @(negedge clk);
    ainv_read = 1'b1;
    @(negedge clk);
    ainv_read = 1'b0;
    chk("extra_valid", ainv_valid, 0);
    chk("extra_elem", ainv_elem, e_v[8]);
    chk("finish_hold", ainv_finish, 1);
    chk("ready_hold", ainv_ready, 1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_ready", ainv_ready, 0);
    chk("start_valid", ainv_valid, 0);
    chk("start_finish", ainv_finish, 0);
    chk("start_rd", rinv_read, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; rinv_dnload = 1'b0; rinv_finish = 1'b0;
    q_valid = 1'b0; ainv_read = 1'b0; rinv_elem = '0; q_elem = '0;
    repeat (3) @(negedge clk);
    chk("rst_rd", rinv_read, 0);
    chk("rst_ready", ainv_ready, 0);
    chk("rst_valid", ainv_valid, 0);
    chk("rst_finish", ainv_finish, 0);
    chk("rst_elem", ainv_elem, 0);
    rst_n = 1'b1;

    // Identity Q: result equals R_inv.
    r_v = '{16'h1000, 16'h0800, 16'hF800, 16'h0000, 16'h2000, 16'h0400, 16'h0000, 16'h0000, 16'h0C00};
    q_v = '{16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h1000, 16'h0000, 16'h0000, 16'h0000, 16'h1000};
    e_v = r_v;
    load_q(1'b0);
    run_load(-1, 1'b1);
    readout();

    // Reset in the middle of LOAD_R.
    r_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h1000, 16'h0000, 16'h0001};
    q_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0400, 16'h0800, 16'h0000, 16'h0000, 16'h0000, 16'h0800};
    e_v = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 16'h0400, 16'h0000};
    pulse_start();
    load_q(1'b0);
    run_load(4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", rinv_read, 0);
    chk("mid_rst_ready", ainv_ready, 0);
    chk("mid_rst_valid", ainv_valid, 0);
    chk("mid_rst_finish", ainv_finish, 0);
    chk("mid_rst_elem", ainv_elem, 0);
    @(negedge clk);
    rst_n = 1'b1;
    // Transposed access, truncation toward minus infinity.
    load_q(1'b0);
    run_load(-1, 1'b0);
    readout();

    // Single product, with a 10th Q element that must be ignored.
    r_v = '{16'h2000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    q_v = '{16'h1800, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    e_v = '{16'h3000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start();
    load_q(1'b1);
    run_load(-1, 1'b1);
    readout();

    // Positive saturation.
    r_v = '{16'h7000, 16'h7000, 16'h7000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    q_v = '{16'h7000, 16'h7000, 16'h7000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    e_v = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start();
    load_q(1'b0);
    run_load(-1, 1'b0);
    readout();

    // Negative saturation, after a start abandoned mid-COMPUTE.
    q_v = '{16'h9000, 16'h9000, 16'h9000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    e_v = '{16'h8000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    pulse_start();
    load_q(1'b0);
    run_load(20, 1'b0);
    pulse_start();
    load_q(1'b0);
    run_load(-1, 1'b1);
    readout();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rinv_qt_mult.md
RINV_QT_MULT -- requirements
Module: rinv_qt_mult

Interface
REQ-001 Parameter SIZE, 16, element width in bits (signed two's complement).
REQ-002 Parameter FRAC, 12, fractional bits (Q4.12 at defaults).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle pulse; synchronous restart of a new inversion.
REQ-006 rinv_dnload  in  1  level; upstream R-inverse matrix held and ready to stream.
REQ-007 rinv_read  out  1  request to upstream; each high cycle requests the next element.
REQ-008 rinv_elem  in  SIZE  upstream R-inverse element, row-major, one cycle after each request.
REQ-009 rinv_finish  in  1  upstream last-element flag; informational, not required for capture.
REQ-010 q_valid  in  1  Q element strobe.
REQ-011 q_elem  in  SIZE  Q element, row-major order Q[0][0]..Q[2][2].
REQ-012 ainv_read  in  1  downstream request; one A-inverse element per high cycle.
REQ-013 ainv_ready  out  1  level; A-inverse result buffer complete and readable.
REQ-014 ainv_elem  out  SIZE  registered A-inverse element, row-major.
REQ-015 ainv_valid  out  1  ainv_elem holds a new element this cycle.
REQ-016 ainv_finish  out  1  high from the cycle element [2][2] is presented until next start or reset.

Function
REQ-017 The block SHALL compute A_inv = R_inv x Q^T, i.e. A_inv[i][j] = sum over k=0..2 of R_inv[i][k]*Q[j][k].
REQ-018 FSM states SHALL be IDLE, LOAD_R, WAIT_Q, COMPUTE, OUT.
REQ-019 IDLE -> LOAD_R when rinv_dnload=1; LOAD_R drives rinv_read high for exactly 9 consecutive cycles.
REQ-020 rinv_elem SHALL be captured on the cycle after each rinv_read-high cycle, element index 0..8 row-major.
REQ-021 LOAD_R -> WAIT_Q after the 9th capture; WAIT_Q -> COMPUTE when all 9 Q elements held (immediate if already held).
REQ-022 q_valid SHALL be accepted in IDLE, LOAD_R, WAIT_Q; 4-bit index increments per accept; accepts beyond 9 ignored; q_valid in COMPUTE/OUT ignored.
REQ-023 COMPUTE SHALL perform one signed SIZExSIZE multiply-accumulate per cycle, k inner, j middle, i outer: 27 cycles total, zero terms included.
REQ-024 Accumulator SHALL be 2*SIZE+2 bits, cleared at k=0; result = accumulator >>> FRAC (arithmetic, truncation toward minus infinity).
REQ-025 Result SHALL saturate to [-2^(SIZE-1), 2^(SIZE-1)-1] before storage into a 9-entry result buffer.
REQ-026 COMPUTE -> OUT on the cycle after the 27th MAC; ainv_ready=1 throughout OUT.
REQ-027 In OUT, each ainv_read-high cycle SHALL load the next buffer element into ainv_elem with ainv_valid=1 on the following cycle; ainv_read low holds ainv_elem and drops ainv_valid.
REQ-028 ainv_read outside OUT, or after element 8, SHALL be ignored; OUT is left only by start or reset.
REQ-029 start SHALL, in any state, return FSM to IDLE, clear Q and R indices, Q-held flag, ainv_ready, ainv_valid, ainv_finish; start wins over simultaneous q_valid (element discarded).
REQ-030 rinv_read SHALL never be high outside LOAD_R.

Reset
REQ-031 On rst_n=0: FSM IDLE; rinv_read, ainv_ready, ainv_valid, ainv_finish = 0; ainv_elem = 0; all counters, accumulator, R/Q/result buffers = 0.
REQ-032 Reset mid-operation SHALL abandon all captured data; no output pulses occur until a new full sequence.

Structure
REQ-033 Shared package matinv_pkg SHALL hold SIZE/FRAC/N=3 defaults and the FSM state enum type.
REQ-034 One sub-module fxp_mac_sat SHALL hold the multiply, accumulator, shift and saturation.

Verification
REQ-035 Q=identity (0x1000 diag), R_inv rows {0x1000,0x0800,0xF800},{0,0x2000,0x0400},{0,0,0x0C00} -> A_inv equals R_inv element-for-element.
REQ-036 R_inv[0][0]=0x2000, rest 0; Q[0][0]=0x1800 -> A_inv[0][0]=0x3000, others 0x0000.
REQ-037 R_inv row0 all 0x7000, Q row0 all 0x7000 -> A_inv[0][0]=0x7FFF; same with Q row0 all 0x9000 -> 0x8000.
REQ-038 Handshake timing: rinv_dnload high -> rinv_read high exactly 9 cycles; ainv_ready 27 cycles after WAIT_Q->COMPUTE; ainv_read toggled every other cycle -> 9 valid pulses, ainv_finish with the 9th.
REQ-039 start asserted mid-COMPUTE and rst_n asserted mid-LOAD_R -> outputs return to reset values, following full sequence produces correct A_inv.
